// File: rtl/pu_flow_mem_atomic_pkg.sv
// pu_flow_mem_atomic_pkg: shared constants, command/slot types and op decode for the PU flow memory
package pu_flow_mem_atomic_pkg;
  localparam int FLOW_FID_NBITS = 8;
  localparam int FLOW_PD_NBITS = 6;
  localparam int FLOW_WORD_NBITS = FLOW_PD_NBITS - 2;
  localparam int FLOW_WIDTH = 32;
  localparam int REGION_NBITS = 4;
  localparam int IO_ADDR_NBITS = REGION_NBITS + FLOW_WORD_NBITS;
  localparam logic [REGION_NBITS-1:0] PU_FLOW_MEM = 4'hA;
  typedef enum logic [1:0] {RD, WR, ADD} pu_mem_op_e;
  typedef struct packed {
    logic wr;
    logic [IO_ADDR_NBITS-1:0] addr;
    logic [FLOW_FID_NBITS-1:0] fid;
    logic [FLOW_WIDTH-1:0] wdata;
  } io_type;
  typedef struct packed {
    pu_mem_op_e op;
    logic [FLOW_FID_NBITS-1:0] fid;
    logic [FLOW_WORD_NBITS-1:0] word;
    logic [FLOW_WIDTH-1:0] wdata;
  } pend_slot_t;
  function automatic logic region_hit(input logic [IO_ADDR_NBITS-1:0] addr);
    return addr[IO_ADDR_NBITS-1 -: REGION_NBITS] == PU_FLOW_MEM;
  endfunction
  function automatic pu_mem_op_e decode_op(input logic wr, input logic atomic);
    return wr ? WR : atomic ? ADD : RD;
  endfunction
endpackage

// File: rtl/pu_flow_mem_atomic_rr_arb_n.sv
// rr_arb_n: N-way round-robin arbiter with a per-request mask
// Ports: clk, rst (async high), req/mask [N], gnt_v, gnt_idx; pointer moves past each winner.
module rr_arb_n #(
  parameter int N = 20,
  parameter int ID_NBITS = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        req,
  input  logic [N-1:0]        mask,
  output logic                gnt_v,
  output logic [ID_NBITS-1:0] gnt_idx
);
  logic [ID_NBITS-1:0] ptr;
  logic [N-1:0] elig;
  assign elig = req & ~mask;
  // Scan downward so the last hit written is the first eligible index at or after ptr.
  always_comb begin
    gnt_v = 1'b0;
    gnt_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (elig[(int'(ptr) + k) % N]) begin
        gnt_v = 1'b1;
        gnt_idx = ID_NBITS'((int'(ptr) + k) % N);
      end
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr <= '0;
    else if (gnt_v) ptr <= gnt_idx == ID_NBITS'(N - 1) ? '0 : gnt_idx + 1'b1;
endmodule

// File: rtl/pu_flow_mem_atomic.sv
// pu_flow_mem_atomic: shared flow RAM with per-PU slots, round-robin RD/WR/fetch-and-add and writeback bypass
// Ports: clk, rst (async high); io_req/io_cmd/io_atomic per PU in; io_busy, io_ack, io_ack_data, io_err (sticky) per PU out.
module pu_flow_mem_atomic
  import pu_flow_mem_atomic_pkg::*;
#(
  parameter int NUM_OF_PU = 20,
  parameter int WIDTH_NBITS = FLOW_WIDTH,
  parameter int FID_NBITS = FLOW_FID_NBITS,
  parameter int WORD_NBITS = FLOW_WORD_NBITS,
  parameter int DEPTH_NBITS = FID_NBITS + WORD_NBITS,
  parameter int PU_ID_NBITS = $clog2(NUM_OF_PU)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_OF_PU-1:0]   io_req,
  input  io_type                 io_cmd [NUM_OF_PU],
  input  logic [NUM_OF_PU-1:0]   io_atomic,
  output logic [NUM_OF_PU-1:0]   io_busy,
  output logic [NUM_OF_PU-1:0]   io_ack,
  output logic [WIDTH_NBITS-1:0] io_ack_data [NUM_OF_PU],
  output logic [NUM_OF_PU-1:0]   io_err
);
  localparam int N = NUM_OF_PU;
  logic [N-1:0] pend, err, hit, acc, drop, wmask, mask, gnt_oh;
  pend_slot_t slot [N];
  pend_slot_t g_slot;
  logic g_v, s1_v, s1_byp, s2_v, wb_add, ram_wr;
  logic [PU_ID_NBITS-1:0] g_idx, s1_pu, s2_pu;
  pu_mem_op_e s1_op;
  logic [DEPTH_NBITS-1:0] g_addr, s1_addr, waddr;
  logic [WIDTH_NBITS-1:0] s1_wdata, s1_byp_data, s1_data, wb_sum, rdata, s2_data, ram_wdata;
  logic [WIDTH_NBITS-1:0] mem [2**DEPTH_NBITS];
  always_comb begin
    for (int i = 0; i < N; i++) begin
      hit[i] = io_req[i] & region_hit(io_cmd[i].addr);
      wmask[i] = slot[i].op != RD;
    end
  end
  assign acc = hit & ~pend;
  assign drop = hit & pend;
  // The ADD writeback owns the write port the cycle after its grant.
  assign mask = wb_add ? wmask : '0;
  rr_arb_n #(.N(N), .ID_NBITS(PU_ID_NBITS)) u_arb (
    .clk(clk), .rst(rst), .req(pend), .mask(mask), .gnt_v(g_v), .gnt_idx(g_idx)
  );
  assign gnt_oh = g_v ? {{(N-1){1'b0}}, 1'b1} << g_idx : '0;
  assign g_slot = slot[g_idx];
  assign g_addr = {g_slot.fid, g_slot.word};
  assign wb_add = s1_v && s1_op == ADD;
  assign s1_data = s1_byp ? s1_byp_data : rdata;
  assign wb_sum = s1_data + s1_wdata;
  assign ram_wr = wb_add || (g_v && g_slot.op == WR);
  assign waddr = wb_add ? s1_addr : g_addr;
  assign ram_wdata = wb_add ? wb_sum : g_slot.wdata;
  // Read-first RAM: a read in the writeback cycle sees old data, hence the bypass.
  always_ff @(posedge clk) begin
    if (ram_wr) mem[waddr] <= ram_wdata;
    rdata <= mem[g_addr];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pend <= '0;
      err <= '0;
      for (int i = 0; i < N; i++) slot[i] <= '0;
    end else begin
      pend <= (pend & ~gnt_oh) | acc;
      err <= err | drop;
      for (int i = 0; i < N; i++)
        if (acc[i]) slot[i] <= '{op: decode_op(io_cmd[i].wr, io_atomic[i]), fid: io_cmd[i].fid,
                                 word: io_cmd[i].addr[WORD_NBITS-1:0], wdata: io_cmd[i].wdata};
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_v <= 1'b0;
      s1_pu <= '0;
      s1_op <= RD;
      s1_addr <= '0;
      s1_wdata <= '0;
      s1_byp <= 1'b0;
      s1_byp_data <= '0;
      s2_v <= 1'b0;
      s2_pu <= '0;
      s2_data <= '0;
    end else begin
      s1_v <= g_v;
      s1_pu <= g_idx;
      s1_op <= g_slot.op;
      s1_addr <= g_addr;
      s1_wdata <= g_slot.wdata;
      s1_byp <= g_v && wb_add && g_slot.op != WR && g_addr == s1_addr;
      s1_byp_data <= wb_sum;
      s2_v <= s1_v;
      s2_pu <= s1_pu;
      s2_data <= s1_op == WR ? '0 : s1_data;
    end
  always_comb begin
    for (int i = 0; i < N; i++) begin
      io_ack[i] = s2_v && s2_pu == PU_ID_NBITS'(i);
      io_ack_data[i] = (s2_v && s2_pu == PU_ID_NBITS'(i)) ? s2_data : '0;
    end
  end
  assign io_busy = pend;
  assign io_err = err;
endmodule

// File: tb/tb_pu_flow_mem_atomic.sv
// tb_pu_flow_mem_atomic: randomized + directed scoreboard bench for pu_flow_mem_atomic
module tb_pu_flow_mem_atomic;
  import pu_flow_mem_atomic_pkg::*;
  localparam int NP = 20;
  logic clk = 1'b0, rst = 1'b1;
  logic [NP-1:0] io_req, io_atomic, io_busy, io_ack, io_err;
  io_type io_cmd [NP];
  logic [31:0] io_ack_data [NP];
  typedef struct {int op; int a; logic [31:0] d;} op_t;
  typedef struct {int pu; int cyc; logic [31:0] d;} ack_t;
  op_t exp_q [NP][$];
  ack_t ack_log [$];
  logic [31:0] mdl [4096];
  logic [NP-1:0] merr;
  op_t e;
  int cyc = 0, checks = 0, fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pu_flow_mem_atomic dut (
    .clk(clk), .rst(rst), .io_req(io_req), .io_cmd(io_cmd), .io_atomic(io_atomic),
    .io_busy(io_busy), .io_ack(io_ack), .io_ack_data(io_ack_data), .io_err(io_err)
  );

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", n, act, expv, cyc);
    end
  endtask

  // Reference model: ops take effect on a flat memory in the order they complete.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NP; i++) begin
        if (io_ack[i]) begin
          if (exp_q[i].size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_ack pu%0d: got an ack, expected none (cycle %0d)", i, cyc);
          end else begin
            e = exp_q[i].pop_front();
            chk($sformatf("ack_data_pu%0d", i), io_ack_data[i], e.op == 1 ? 32'h0 : mdl[e.a]);
            if (e.op == 1) mdl[e.a] = e.d;
            else if (e.op == 2) mdl[e.a] = mdl[e.a] + e.d;
            ack_log.push_back('{i, cyc, io_ack_data[i]});
          end
        end else if (io_ack_data[i] != 0) chk($sformatf("idle_lane_pu%0d", i), io_ack_data[i], 32'h0);
      end
    end
  end

  function automatic int addr_of(int k);
    return k < 20 ? (k / 4) * 16 + k % 4 : 96 + (k - 20);
  endfunction

  function automatic bit idle();
    idle = io_busy == 0;
    for (int i = 0; i < NP; i++) if (exp_q[i].size() != 0) idle = 1'b0;
  endfunction

  task automatic issue(input int pu, input int op, input int a, input logic [31:0] d, input bit bad = 1'b0);
    io_req[pu] = 1'b1;
    io_atomic[pu] = (op == 2) || (op == 1 && $urandom_range(1) == 1);
    io_cmd[pu].wr = op == 1;
    io_cmd[pu].addr = {bad ? 4'h3 : PU_FLOW_MEM, 4'(a)};
    io_cmd[pu].fid = 8'(a >> 4);
    io_cmd[pu].wdata = d;
    if (!bad) begin
      if (io_busy[pu]) merr[pu] = 1'b1;
      else exp_q[pu].push_back('{op, a, d});
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    io_req = '0;
    io_atomic = '0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!idle() && n < 300) begin
      step();
      n++;
    end
    chk("drain_timeout", 32'(idle()), 32'h1);
    repeat (3) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < NP; i++) exp_q[i].delete();
    merr = '0;
    @(negedge clk);
    chk("rst_busy", 32'(io_busy), 32'h0);
    chk("rst_ack", 32'(io_ack), 32'h0);
    chk("rst_err", 32'(io_err), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int t0, n6, r, k;
    logic [31:0] v;
    io_req = '0;
    io_atomic = '0;
    merr = '0;
    for (int i = 0; i < NP; i++) io_cmd[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 32'(io_busy), 32'h0);
    chk("reset_ack", 32'(io_ack), 32'h0);
    chk("reset_err", 32'(io_err), 32'h0);
    chk("reset_ack_data0", io_ack_data[0], 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 22; i++) begin
      issue(i % NP, 1, addr_of(i), $urandom);
      step();
      if (i == 19) wait_idle();
    end
    wait_idle();
    // Write then read back with fixed latency.
    ack_log.delete();
    t0 = cyc;
    issue(3, 1, 82, 32'hDEADBEEF);
    repeat (4) step();
    issue(3, 0, 82, 0);
    step();
    wait_idle();
    chk("wr_rd_count", ack_log.size(), 2);
    if (ack_log.size() == 2) begin
      chk("wr_ack_cycle", ack_log[0].cyc - t0, 3);
      chk("wr_ack_data", ack_log[0].d, 32'h0);
      chk("rd_ack_cycle", ack_log[1].cyc - t0, 7);
      chk("rd_ack_data", ack_log[1].d, 32'hDEADBEEF);
    end
    // All PUs read at once straight out of reset: one ack per cycle in PU order.
    do_reset();
    ack_log.delete();
    t0 = cyc;
    for (int i = 0; i < NP; i++) issue(i, 0, addr_of(i), 0);
    step();
    wait_idle();
    chk("all_rd_count", ack_log.size(), NP);
    for (int i = 0; i < NP && i < ack_log.size(); i++) begin
      chk($sformatf("all_rd_pu_%0d", i), ack_log[i].pu, i);
      chk($sformatf("all_rd_cyc_%0d", i), ack_log[i].cyc - t0, 3 + i);
    end
    chk("all_rd_err", 32'(io_err), 32'h0);
    // Two fetch-and-adds on one word: the second waits out the write-port slot.
    issue(0, 1, 96, 10);
    step();
    wait_idle();
    ack_log.delete();
    t0 = cyc;
    issue(1, 2, 96, 1);
    issue(2, 2, 96, 5);
    step();
    wait_idle();
    issue(3, 0, 96, 0);
    step();
    wait_idle();
    chk("add_count", ack_log.size(), 3);
    if (ack_log.size() == 3) begin
      chk("add1_pu", ack_log[0].pu, 1);
      chk("add1_cyc", ack_log[0].cyc - t0, 3);
      chk("add1_data", ack_log[0].d, 10);
      chk("add2_pu", ack_log[1].pu, 2);
      chk("add2_cyc", ack_log[1].cyc - t0, 5);
      chk("add2_data", ack_log[1].d, 11);
      chk("add_final", ack_log[2].d, 16);
    end
    // Read right behind an add to the same word gets the forwarded sum.
    v = $urandom;
    issue(9, 1, 97, v);
    step();
    wait_idle();
    ack_log.delete();
    t0 = cyc;
    issue(0, 2, 97, 7);
    issue(4, 0, 97, 0);
    step();
    wait_idle();
    chk("byp_count", ack_log.size(), 2);
    if (ack_log.size() == 2) begin
      chk("byp_add_data", ack_log[0].d, v);
      chk("byp_rd_pu", ack_log[1].pu, 4);
      chk("byp_rd_cyc", ack_log[1].cyc - t0, 4);
      chk("byp_rd_data", ack_log[1].d, v + 32'd7);
    end
    // Request while busy is dropped and flagged.
    ack_log.delete();
    issue(6, 0, addr_of(0), 0);
    step();
    chk("busy6", 32'(io_busy[6]), 32'h1);
    issue(6, 0, addr_of(1), 0);
    step();
    wait_idle();
    chk("err6", 32'(io_err[6]), 32'h1);
    n6 = 0;
    foreach (ack_log[j]) if (ack_log[j].pu == 6) n6++;
    chk("single_ack6", n6, 1);
    // Reset with reads in flight; RAM keeps its contents.
    issue(7, 0, addr_of(0), 0);
    issue(8, 0, addr_of(1), 0);
    issue(9, 0, addr_of(2), 0);
    step();
    step();
    do_reset();
    ack_log.delete();
    issue(10, 0, addr_of(1), 0);
    step();
    wait_idle();
    chk("post_rst_acks", ack_log.size(), 1);
    // Random traffic against the model.
    repeat (400) begin
      for (int p = 0; p < NP; p++) begin
        r = $urandom_range(99);
        k = $urandom_range(21);
        if ((r < 20 && !io_busy[p]) || r == 0) issue(p, $urandom_range(2), addr_of(k), $urandom);
        else if (r == 99) issue(p, $urandom_range(2), addr_of(k), $urandom, 1'b1);
      end
      step();
    end
    wait_idle();
    chk("rand_err_vec", 32'(io_err), 32'(merr));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation still running at cycle %0d, expected to have finished", cyc);
    $fatal(1);
  end
endmodule
